// File: rtl/pixel_frame_sequencer.sv
// Raster-order pixel coordinate sequencer for one frame of the edge-detector pipeline.
// Latches the stage enables at frame start, drains the pipeline after the last pixel and counts frames.
module pixel_frame_sequencer #(
   parameter int WIDTH      = 5,
   parameter int HEIGHT     = 30,
   parameter int PIPE_DEPTH = 3,
   parameter int COORD_W    = 8,
   parameter int COUNT_W    = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [2:0]         stageEnableIn,
   input  logic               outReady,
   output logic               pixelValid,
   output logic [COORD_W-1:0] pixelX,
   output logic [COORD_W-1:0] pixelY,
   output logic               startOfFrame,
   output logic               endOfLine,
   output logic               endOfFrame,
   output logic [2:0]         stageEnable,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] frameCount,
   output logic [1:0]         fsmState
);

   localparam int DW = (PIPE_DEPTH < 1) ? 1 : $clog2(PIPE_DEPTH + 1);
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
   localparam logic [DW-1:0] D_LAST = DW'((PIPE_DEPTH == 0) ? 0 : PIPE_DEPTH - 1);

   if (COORD_W < 31 && ((WIDTH - 1) >= (1 << COORD_W) || (HEIGHT - 1) >= (1 << COORD_W))) begin : g_width_check
      $error("pixel_frame_sequencer: COORD_W too narrow for WIDTH/HEIGHT");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state, stateNext;
   logic [COORD_W-1:0] x, y, xNext, yNext;
   logic [DW-1:0]      drainCount, drainNext;
   logic [2:0]         stageNext;
   logic [COUNT_W-1:0] countNext;
   logic               xfer;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         x           <= '0;
         y           <= '0;
         drainCount  <= '0;
         stageEnable <= '0;
         frameCount  <= '0;
      end else begin
         state       <= stateNext;
         x           <= xNext;
         y           <= yNext;
         drainCount  <= drainNext;
         stageEnable <= stageNext;
         frameCount  <= countNext;
      end
   end

   // Handshake: a pixel (RUN) or a drain step (DRAIN) completes on a cycle where the
   // sequencer offers it and outReady=1; otherwise coordinates and markers hold.
   assign xfer = (state == RUN) && outReady;

   always_comb begin
      stateNext = state;
      xNext     = x;
      yNext     = y;
      drainNext = drainCount;
      stageNext = stageEnable;
      countNext = frameCount;
      case (state)
         IDLE: begin
            xNext = '0;
            yNext = '0;
            if (start && !abort) begin
               stateNext = RUN;
               stageNext = stageEnableIn;
            end
         end
         RUN: begin
            if (abort) begin
               stateNext = IDLE;
               xNext     = '0;
               yNext     = '0;
            end else if (xfer) begin
               if (x == X_LAST) begin
                  xNext = '0;
                  if (y == Y_LAST) begin
                     yNext     = '0;
                     drainNext = '0;
                     stateNext = (PIPE_DEPTH == 0) ? DONE : DRAIN;
                  end else begin
                     yNext = y + 1'b1;
                  end
               end else begin
                  xNext = x + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (abort) begin
               stateNext = IDLE;
               drainNext = '0;
            end else if (outReady) begin
               // The final ready step moves straight to DONE instead of counting past PIPE_DEPTH-1.
               if (drainCount == D_LAST) begin
                  stateNext = DONE;
                  drainNext = '0;
               end else begin
                  drainNext = drainCount + 1'b1;
               end
            end
         end
         DONE: begin
            stateNext = IDLE;
            countNext = frameCount + 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign pixelValid   = (state == RUN);
   assign pixelX       = x;
   assign pixelY       = y;
   assign startOfFrame = pixelValid && (x == '0) && (y == '0);
   assign endOfLine    = pixelValid && (x == X_LAST);
   assign endOfFrame   = endOfLine && (y == Y_LAST);
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);
   assign fsmState     = state;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer with a 5x4 frame and 3-stage drain.
module tb_pixel_frame_sequencer;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int PD = 3;
  localparam int CW = 8;
  localparam int NW = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic outReady = 1'b0;
  logic [2:0] stageEnableIn = 3'b000;
  logic pixelValid, startOfFrame, endOfLine, endOfFrame, busy, done;
  logic [CW-1:0] pixelX, pixelY;
  logic [2:0] stageEnable;
  logic [NW-1:0] frameCount;
  logic [1:0] fsmState;

  int checks = 0;
  int failures = 0;
  int dones;

  always #5 clock = ~clock;

  pixel_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .PIPE_DEPTH(PD), .COORD_W(CW), .COUNT_W(NW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .stageEnableIn(stageEnableIn), .outReady(outReady),
    .pixelValid(pixelValid), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .endOfLine(endOfLine), .endOfFrame(endOfFrame),
    .stageEnable(stageEnable), .busy(busy), .done(done),
    .frameCount(frameCount), .fsmState(fsmState)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_state", fsmState, 0);
    chk("rst_valid", pixelValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", pixelX, 0);
    chk("rst_y", pixelY, 0);
    chk("rst_sof", startOfFrame, 0);
    chk("rst_stage", stageEnable, 0);
    chk("rst_count", frameCount, 0);

    // frame 1: outReady=1, stageEnable 101, mid-frame start and enable change ignored
    stageEnableIn = 3'b101;
    outReady = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      tick();
      start = (k == 6);
      if (k == 4) stageEnableIn = 3'b010;
      chk("f1_valid", pixelValid, (k <= 20));
      if (k <= 20) begin
        chk("f1_x", pixelX, (k - 1) % W);
        chk("f1_y", pixelY, (k - 1) / W);
      end
      chk("f1_sof", startOfFrame, (k == 1));
      chk("f1_eol", endOfLine, (k <= 20) && (k % W == 0));
      chk("f1_eof", endOfFrame, (k == 20));
      chk("f1_done", done, (k == 24));
      chk("f1_busy", busy, (k <= 24));
      chk("f1_stage", stageEnable, 3'b101);
    end
    chk("f1_count", frameCount, 1);

    // frame 2: outReady 0,1,0,1... so every pixel and drain step takes two cycles
    start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 49; k++) begin
      tick();
      start = 1'b0;
      outReady = (k % 2 == 0);
      chk("f2_valid", pixelValid, (k <= 40));
      if (k <= 40) begin
        chk("f2_x", pixelX, ((k - 1) / 2) % W);
        chk("f2_y", pixelY, ((k - 1) / 2) / W);
        chk("f2_eol", endOfLine, (((k - 1) / 2) % W) == W - 1);
      end
      chk("f2_done", done, (k == 47));
      chk("f2_stage", stageEnable, 3'b010);
      if (done) dones++;
    end
    chk("f2_done_once", dones, 1);
    chk("f2_count", frameCount, 2);

    // frame 3: abort at pixel (2,1) with outReady=1
    outReady = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 1'b0;
    end
    chk("ab_x", pixelX, 2);
    chk("ab_y", pixelY, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", pixelValid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_state", fsmState, 0);
    chk("ab_x0", pixelX, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ab_no_done", done, 0);
    end
    chk("ab_count", frameCount, 2);

    // start with abort in IDLE: abort wins; then a clean restart at (0,0)
    start = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    tick();
    start = 1'b0;
    chk("rs_valid", pixelValid, 1);
    chk("rs_x", pixelX, 0);
    chk("rs_y", pixelY, 0);
    chk("rs_sof", startOfFrame, 1);

    // run to DRAIN, stall it, then reset between clock edges
    for (int k = 2; k <= 22; k++) begin
      tick();
      if (k == 21) outReady = 1'b0;
    end
    chk("dr_state", fsmState, 2);
    chk("dr_busy", busy, 1);
    chk("dr_valid", pixelValid, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_valid", pixelValid, 0);
    chk("ar_done", done, 0);
    chk("ar_count", frameCount, 0);
    chk("ar_state", fsmState, 0);
    chk("ar_stage", stageEnable, 0);
    #2 reset = 1'b0;
    outReady = 1'b1;

    // start held high: one frame per IDLE visit, start in DONE ignored
    start = 1'b1;
    dones = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 26) start = 1'b0;
      chk("sh_done", done, (k == 24) || (k == 49));
      chk("sh_busy", busy, (k <= 24) || (k >= 26 && k <= 49));
      chk("sh_valid", pixelValid, (k <= 20) || (k >= 26 && k <= 45));
      chk("sh_sof", startOfFrame, (k == 1) || (k == 26));
      if (done) dones++;
    end
    chk("sh_dones", dones, 2);
    chk("sh_count", frameCount, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pixel_frame_sequencer.md
Name: pixel_frame_sequencer

Overview:
- Sequences one frame of pixels through the edge-detector pipeline (edge creation, noise, detect stages).
- Issues raster-order pixel coordinates with a valid/ready handshake.
- Latches the per-stage enable configuration at frame start and drains the pipeline after the last pixel.
- Reports completion and keeps a frame counter. Sits between the system control logic and the pixel datapath.

Parameters:
- WIDTH, 5, pixels per line.
- HEIGHT, 30, lines per frame.
- PIPE_DEPTH, 3, pipeline stages to drain after the last pixel.
- COORD_W, 8, width of the coordinate outputs.
- COUNT_W, 16, width of the frame counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a frame; sampled only in IDLE.
- abort  in  1  cancel the current frame.
- stageEnableIn  in  3  bit0 createEdge, bit1 addNoise, bit2 detect; sampled with start.
- outReady  in  1  pipeline accepts a pixel (or a drain step) this cycle.
- pixelValid  out  1  pixelX/pixelY hold a valid pixel.
- pixelX  out  COORD_W  column, 0..WIDTH-1.
- pixelY  out  COORD_W  line, 0..HEIGHT-1.
- startOfFrame  out  1  high with pixel (0,0).
- endOfLine  out  1  high with pixelX==WIDTH-1.
- endOfFrame  out  1  high with the last pixel.
- stageEnable  out  3  latched configuration, stable for the whole frame.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at frame completion.
- frameCount  out  COUNT_W  completed frames.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high.
- Reset values: state=IDLE, all 1-bit outputs 0, pixelX=pixelY=0, stageEnable=0, frameCount=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN next cycle.
  - stageEnable<=stageEnableIn; x=y=0.
- RUN:
  - pixelValid=1.
  - Transfer occurs when pixelValid&&outReady.
  - No transfer: pixelX, pixelY and all frame markers hold stable.
  - On transfer, x increments. At x==WIDTH-1, x wraps to 0 and y increments.
  - Transfer of (WIDTH-1,HEIGHT-1) → DRAIN, drainCount=0, pixelValid=0 next cycle.
- DRAIN:
  - pixelValid=0.
  - drainCount increments only on cycles with outReady=1, so a stalled pipeline holds the drain.
  - drainCount reaches PIPE_DEPTH → DONE.
  - PIPE_DEPTH=0 → go directly to DONE.
- DONE:
  - done=1 for exactly one cycle; frameCount increments (wraps at 2^COUNT_W).
  - Next state IDLE. start in the DONE cycle is ignored; start is accepted again from the next IDLE cycle.
- Frame markers are combinational from state and x/y and are valid only while pixelValid=1:
  - startOfFrame: x==0 && y==0.
  - endOfLine: x==WIDTH-1.
  - endOfFrame: endOfLine && y==HEIGHT-1.
- Latency: start in IDLE at cycle N → first pixelValid at N+1.
  - With outReady held at 1: done at N+1+WIDTH*HEIGHT+PIPE_DEPTH.
- start while busy=1 is ignored; stageEnableIn changes mid-frame do not affect stageEnable.
- abort:
  - In RUN or DRAIN: → IDLE next cycle, pixelValid=0, no done pulse, frameCount unchanged, x=y=0.
  - abort has priority over a transfer in the same cycle.
  - abort in IDLE or DONE: no effect; DONE still completes.
  - abort and start together in IDLE: abort wins, remain IDLE.
- Reset asserted mid-frame: all outputs return to reset values immediately, regardless of clock.
- Width rules:
  - COORD_W must hold max(WIDTH,HEIGHT)-1; an elaboration-time check flags violations.
  - Counters never exceed WIDTH-1, HEIGHT-1, PIPE_DEPTH.

Test Plan:
- WIDTH=5, HEIGHT=4, PIPE_DEPTH=3, outReady=1, start pulse at cycle 10 → pixelValid cycles 11..30, (0,0) with startOfFrame at 11, endOfLine at 15/20/25/30, endOfFrame at 30, done at 34, frameCount=1.
- Same config, outReady toggled 1,0,1,0… → each pixel held 2 cycles with coordinates stable during stalls; 20 transfers total; drain takes 3 ready cycles; done exactly once.
- start with stageEnableIn=3'b101, then stageEnableIn=3'b010 at cycle 15 → stageEnable stays 101 until the next start, then becomes 010.
- abort asserted at pixel (2,1) together with outReady=1 → pixelValid=0 next cycle, no done, frameCount unchanged. New start restarts at (0,0).
- Asynchronous reset pulse mid-DRAIN, between clock edges → busy, pixelValid and done go 0 immediately, frameCount=0, state IDLE.
- start held high through a full frame → exactly one frame per IDLE visit; start in the DONE cycle is ignored. A second frame begins the cycle after IDLE is re-entered, and frameCount reaches 2 after the second done.
